// File: rtl/cdc_sync_pkg.sv
// Shared limits and types for the multi-bit level synchroniser / glitch filter.
package cdc_sync_pkg;

    localparam int STAGES_MIN     = 2;
    localparam int STAGES_MAX     = 4;
    localparam int FILTER_LEN_MAX = 255;
    localparam int GLITCH_CNT_W   = 16;

    typedef logic [GLITCH_CNT_W-1:0] glitch_cnt_t;

endpackage

// File: rtl/sync_bit_filter.sv
// One bit: flop synchroniser chain, optional stability filter and registered
// rise/fall pulses aligned with the first cycle sync_out shows a new level.
module sync_bit_filter #(
    parameter int   STAGES     = 2,
    parameter int   FILTER_LEN = 0,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk_rcv,
    input  logic reset,
    input  logic data_in,
    output logic sync_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic edge_next,
    output logic glitch
);

    logic [STAGES-1:0] r_chain;
    logic              w_raw;
    logic              w_sync_next;

    always_ff @(posedge clk_rcv or posedge reset) begin
        if (reset) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], data_in};
        end
    end

    assign w_raw = r_chain[STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            // The stage feeding raw is next cycle's sync_out, so pulses can be registered.
            assign w_sync_next = r_chain[STAGES-2];
            assign sync_out    = w_raw;
            assign glitch      = 1'b0;
        end else begin : g_filter
            localparam logic [7:0] CNT_TC = 8'(FILTER_LEN - 1);

            logic [7:0] r_cnt;
            logic       r_sync;

            always_ff @(posedge clk_rcv or posedge reset) begin
                if (reset) begin
                    r_cnt  <= 8'd0;
                    r_sync <= RESET_VAL;
                end else if (w_raw == r_sync) begin
                    r_cnt <= 8'd0;
                end else if (r_cnt == CNT_TC) begin
                    r_sync <= w_raw;
                    r_cnt  <= 8'd0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end

            assign w_sync_next = ((w_raw != r_sync) && (r_cnt == CNT_TC)) ? w_raw : r_sync;
            assign sync_out    = r_sync;
            // Raw fell back to the accepted level before the count completed.
            assign glitch      = (w_raw == r_sync) && (r_cnt != 8'd0);
        end
    endgenerate

    always_ff @(posedge clk_rcv or posedge reset) begin
        if (reset) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= w_sync_next & ~sync_out;
            fall_pulse <= ~w_sync_next & sync_out;
        end
    end

    assign edge_next = w_sync_next ^ sync_out;

endmodule

// File: rtl/cdc_sync_filter.sv
// DATA_WIDTH independent level synchronisers with optional per-bit stability
// filtering, edge pulses and a saturating count of glitch-reject cycles.
module cdc_sync_filter
    import cdc_sync_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    STAGES     = 2,
    parameter int                    FILTER_LEN = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                    clk_rcv,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   sync_out,
    output logic [DATA_WIDTH-1:0]   rise_pulse,
    output logic [DATA_WIDTH-1:0]   fall_pulse,
    output logic                    change,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

    generate
        if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
            $error("cdc_sync_filter: STAGES must be within 2..4");
        end
        if (FILTER_LEN < 0 || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_filter
            $error("cdc_sync_filter: FILTER_LEN must be within 0..255");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] w_edge_next;
    logic [DATA_WIDTH-1:0] w_glitch;
    logic                  r_change;
    glitch_cnt_t           r_glitch_cnt;

    generate
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
            sync_bit_filter #(
                .STAGES     (STAGES),
                .FILTER_LEN (FILTER_LEN),
                .RESET_VAL  (RESET_VAL[i])
            ) u_bit (
                .clk_rcv    (clk_rcv),
                .reset      (reset),
                .data_in    (data_in[i]),
                .sync_out   (sync_out[i]),
                .rise_pulse (rise_pulse[i]),
                .fall_pulse (fall_pulse[i]),
                .edge_next  (w_edge_next[i]),
                .glitch     (w_glitch[i])
            );
        end
    endgenerate

    // One increment per cycle no matter how many bits rejected a glitch.
    always_ff @(posedge clk_rcv or posedge reset) begin
        if (reset) begin
            r_change     <= 1'b0;
            r_glitch_cnt <= '0;
        end else begin
            r_change <= |w_edge_next;
            if ((|w_glitch) && (r_glitch_cnt != '1)) begin
                r_glitch_cnt <= r_glitch_cnt + glitch_cnt_t'(1);
            end
        end
    end

    assign change     = r_change;
    assign glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_cdc_sync_filter.sv
// Directed bench: filtered instance (STAGES=2, FILTER_LEN=3) and bypass
// instance (STAGES=3, FILTER_LEN=0), expectations queued then popped at checks.
module tb_cdc_sync_filter;

    logic        clk_rcv;
    logic        rst_a, rst_b;
    logic [7:0]  din_a, din_b;
    logic [7:0]  sync_a, rise_a, fall_a;
    logic [7:0]  sync_b, rise_b, fall_b;
    logic        chg_a, chg_b;
    logic [15:0] gcnt_a, gcnt_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_gcnt;
    logic        seen;

    cdc_sync_filter #(.DATA_WIDTH(8), .STAGES(2), .FILTER_LEN(3), .RESET_VAL(8'h00)) dut_a (
        .clk_rcv    (clk_rcv),
        .reset      (rst_a),
        .data_in    (din_a),
        .sync_out   (sync_a),
        .rise_pulse (rise_a),
        .fall_pulse (fall_a),
        .change     (chg_a),
        .glitch_cnt (gcnt_a)
    );

    cdc_sync_filter #(.DATA_WIDTH(8), .STAGES(3), .FILTER_LEN(0), .RESET_VAL(8'h00)) dut_b (
        .clk_rcv    (clk_rcv),
        .reset      (rst_b),
        .data_in    (din_b),
        .sync_out   (sync_b),
        .rise_pulse (rise_b),
        .fall_pulse (fall_b),
        .change     (chg_b),
        .glitch_cnt (gcnt_b)
    );

    initial clk_rcv = 1'b0;
    always #5 clk_rcv = ~clk_rcv;

    task automatic push(input logic [15:0] v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs);
        logic [15:0] exp_v;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp_v = sb.pop_front();
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    // Advance n rising edges and settle just past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_rcv);
        #1;
    endtask

    // Run n cycles noting whether any pulse or change appears on instance A.
    task automatic watch_a(input int n);
        seen = 1'b0;
        repeat (n) begin
            tick(1);
            if (chg_a || (rise_a != 8'h00) || (fall_a != 8'h00) || (sync_a != 8'h00)) seen = 1'b1;
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        din_a = 8'h00; din_b = 8'h00;
        exp_gcnt = 16'd0;
        #1;

        push(16'h0000); chk("rst_sync_a",  {8'h00, sync_a});
        push(16'h0000); chk("rst_pulse_a", {rise_a, fall_a});
        push(16'h0000); chk("rst_gcnt_a",  gcnt_a);
        push(16'h0000); chk("rst_sync_b",  {8'h00, sync_b});

        // Rising level through the filter: visible on the 5th edge.
        @(negedge clk_rcv); rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk_rcv); din_a = 8'h01;
        push(16'h0000); tick(4); chk("rise_early_sync", {8'h00, sync_a});
        push(16'h0000); chk("rise_early_chg", {15'd0, chg_a});
        tick(1);
        push(16'h0001); chk("rise_sync", {8'h00, sync_a});
        push(16'h0100); chk("rise_pulses", {rise_a, fall_a});
        push(16'h0001); chk("rise_chg", {15'd0, chg_a});
        tick(1);
        push(16'h0001); chk("rise_hold_sync", {8'h00, sync_a});
        push(16'h0000); chk("rise_one_cycle", {rise_a, 7'd0, chg_a});

        // Single-bit glitch two cycles wide is rejected.
        @(negedge clk_rcv); rst_a = 1'b1; exp_gcnt = 16'd0;
        din_a = 8'h00;
        @(negedge clk_rcv); rst_a = 1'b0;
        @(negedge clk_rcv); din_a = 8'h08;
        @(negedge clk_rcv);
        @(negedge clk_rcv); din_a = 8'h00;
        watch_a(10);
        exp_gcnt = exp_gcnt + 16'd1;
        push(16'h0000); chk("glitch_no_output", {15'd0, seen});
        push(exp_gcnt); chk("glitch_cnt_one", gcnt_a);

        // Two bits glitching in the same cycle count once.
        @(negedge clk_rcv); din_a = 8'h03;
        @(negedge clk_rcv);
        @(negedge clk_rcv); din_a = 8'h00;
        watch_a(10);
        exp_gcnt = exp_gcnt + 16'd1;
        push(16'h0000); chk("glitch2_no_output", {15'd0, seen});
        push(exp_gcnt); chk("glitch2_cnt", gcnt_a);

        // Bypass instance, three stages.
        @(negedge clk_rcv); din_b = 8'hA5;
        push(16'h0000); tick(2); chk("byp_early", {8'h00, sync_b});
        tick(1);
        push(16'h00A5); chk("byp_sync", {8'h00, sync_b});
        push(16'hA500); chk("byp_pulses", {rise_b, fall_b});
        push(16'h0001); chk("byp_chg", {15'd0, chg_b});
        tick(1);
        push(16'h0000); chk("byp_one_cycle", {rise_b, 7'd0, chg_b});
        push(16'h0000); chk("byp_gcnt", gcnt_b);

        // Falling nibble after settling at 0xFF.
        @(negedge clk_rcv); din_a = 8'hFF;
        tick(12);
        push(16'h00FF); chk("settle_ff", {8'h00, sync_a});
        @(negedge clk_rcv); din_a = 8'h0F;
        push(16'h00FF); tick(4); chk("fall_early", {8'h00, sync_a});
        tick(1);
        push(16'h000F); chk("fall_sync", {8'h00, sync_a});
        push(16'h00F0); chk("fall_pulses", {rise_a, fall_a});
        push(16'h0001); chk("fall_chg", {15'd0, chg_a});
        tick(1);
        push(16'h0000); chk("fall_one_cycle", {fall_a, 7'd0, chg_a});
        push(exp_gcnt); chk("fall_gcnt", gcnt_a);

        // Reset mid-filter discards the partial count.
        @(negedge clk_rcv); rst_a = 1'b1;
        @(negedge clk_rcv); din_a = 8'h00; rst_a = 1'b0;
        @(negedge clk_rcv); din_a = 8'h01;
        tick(4);
        #2 rst_a = 1'b1;
        #1;
        push(16'h0000); chk("async_rst_sync", {8'h00, sync_a});
        push(16'h0000); chk("async_rst_gcnt", gcnt_a);
        push(16'h0000); chk("async_rst_pulse", {rise_a, fall_a});
        @(negedge clk_rcv); rst_a = 1'b0;
        push(16'h0000); tick(4); chk("post_rst_early", {8'h00, sync_a});
        push(16'h0000); chk("post_rst_no_chg", {15'd0, chg_a});
        tick(1);
        push(16'h0001); chk("post_rst_sync", {8'h00, sync_a});
        push(16'h0100); chk("post_rst_pulse", {rise_a, fall_a});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_sync_filter.md
CDC_SYNC_FILTER -- requirements
Module: cdc_sync_filter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of independent synchronised bits.
REQ-002 The block SHALL have parameter STAGES, default 2, giving flip-flop synchroniser depth; legal range 2..4.
REQ-003 The block SHALL have parameter FILTER_LEN, default 0, giving the per-bit stability filter length in cycles; legal range 0..255, where 0 = bypass.
REQ-004 The block SHALL have parameter RESET_VAL, default '0, giving the reset value of every chain stage and of sync_out.
REQ-005 The block SHALL have port clk_rcv, input, 1 bit: receive clock; one clock only.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port data_in, input, DATA_WIDTH bits: asynchronous level inputs.
REQ-008 The block SHALL have port sync_out, output, DATA_WIDTH bits: synchronised, filtered levels.
REQ-009 The block SHALL have port rise_pulse, output, DATA_WIDTH bits: per-bit one-cycle pulse on a 0->1 transition of sync_out.
REQ-010 The block SHALL have port fall_pulse, output, DATA_WIDTH bits: per-bit one-cycle pulse on a 1->0 transition of sync_out.
REQ-011 The block SHALL have port change, output, 1 bit: OR of all rise_pulse and fall_pulse bits.
REQ-012 The block SHALL have port glitch_cnt, output, 16 bits: saturating count of cycles in which at least one glitch was rejected.

Function
REQ-013 Each bit SHALL pass through a STAGES-deep flip-flop chain on clk_rcv; the last stage is "raw".
REQ-014 With FILTER_LEN=0, sync_out SHALL equal raw; latency SHALL be exactly STAGES edges from the capturing edge.
REQ-015 With FILTER_LEN=N>0, a per-bit counter SHALL operate at each edge as follows: raw==sync_out -> cnt<=0; raw!=sync_out and cnt==N-1 -> sync_out<=raw and cnt<=0; otherwise cnt<=cnt+1.
REQ-016 A steady input change SHALL therefore appear on sync_out exactly STAGES+N edges after the capturing edge.
REQ-017 A glitch is defined as raw returning to sync_out while cnt>0; in that case the bit SHALL be unchanged and its cnt SHALL clear.
REQ-018 glitch_cnt SHALL increment by 1 per cycle in which any bit glitches, regardless of how many bits glitch, and SHALL saturate at 0xFFFF.
REQ-019 rise_pulse, fall_pulse and change SHALL be registered and high only in the first cycle sync_out shows the new value, for exactly one cycle.
REQ-020 Multiple bits changing in the same cycle SHALL each pulse independently; change SHALL be a single 1-cycle assertion.
REQ-021 An illegal STAGES or FILTER_LEN SHALL cause an elaboration-time error.

Reset
REQ-022 Asserting reset SHALL immediately, without a clock edge, set all chain stages and sync_out to RESET_VAL.
REQ-023 Asserting reset SHALL immediately clear all filter counters, rise_pulse, fall_pulse, change and glitch_cnt to 0.
REQ-024 Reset asserted mid-filter SHALL discard partial counts; after release, a change SHALL require the full STAGES+FILTER_LEN edges.
REQ-025 Reset itself SHALL generate no pulses; a data_in differing from RESET_VAL after release SHALL propagate and pulse normally.

Structure
REQ-026 Package cdc_sync_pkg SHALL hold STAGES_MIN=2, STAGES_MAX=4, FILTER_LEN_MAX=255, GLITCH_CNT_W=16 and typedef glitch_cnt_t.
REQ-027 Sub-module sync_bit_filter SHALL implement one bit's chain, filter counter and edge pulses, instantiated DATA_WIDTH times via generate.
REQ-028 glitch_cnt SHALL be aggregated in the top level.

Verification (DATA_WIDTH=8 unless stated)
REQ-029 STAGES=2, FILTER_LEN=3; reset, then data_in 0x00->0x01 held: sync_out=0x01 exactly 5 edges after the capture edge; rise_pulse=0x01 and change=1 for that one cycle.
REQ-030 STAGES=2, FILTER_LEN=3; bit3 high for 2 cycles, then low: sync_out stays 0x00, no pulses, glitch_cnt=1.
REQ-031 STAGES=2, FILTER_LEN=3; bits 0 and 1 glitch in the same cycle: glitch_cnt increments by exactly 1.
REQ-032 STAGES=3, FILTER_LEN=0; data_in 0x00->0xA5: sync_out=0xA5 after 3 edges, rise_pulse=0xA5 for one cycle.
REQ-033 STAGES=2, FILTER_LEN=3; 0xFF settled, then 0x0F held: fall_pulse=0xF0 and change=1 for one cycle, rise_pulse=0x00.
REQ-034 Reset asserted with cnt=2 pending: all outputs 0 asynchronously; after release, held 0x01 needs the full 5 edges again.
